// File: rtl/float_divide.sv
`default_nettype none
// ============================================================================
// Module   : float_divide
// Desc     : Iterative (one bit per cycle) restoring floating-point divider,
//            c = a / b, with valid/ready handshakes and IEEE special values.
//            Define FLOAT_DIVIDE_ROUND_EN for round-to-nearest-even;
//            otherwise the quotient is truncated.
// Revision : 1.0
// ============================================================================
module float_divide #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] c,
    output logic                 div_by_zero,
    output logic                 invalid
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int QW = MAN_W + 3;
    localparam int CW = $clog2(MAN_W + 4);
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [CW-1:0]        CNT_LAST = CW'(MAN_W + 2);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic signed [EW-1:0] BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [EW-1:0] EMAX     = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EW-1:0] E_ONE    = {{(EW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [QW-1:0]  rem_q, rem_d, quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dz_q, dz_d, inv_q, inv_d;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             sign;

    assign a_exp = a_q[W-2:MAN_W];
    assign b_exp = b_q[W-2:MAN_W];
    assign a_man = a_q[MAN_W-1:0];
    assign b_man = b_q[MAN_W-1:0];
    assign sign  = a_q[W-1] ^ b_q[W-1];

    // Operand classes; subnormals count as zero
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, special, nan_res;
    assign a_zero  = (a_exp == '0);
    assign b_zero  = (b_exp == '0);
    assign a_inf   = (a_exp == EXP_ONES) && (a_man == '0);
    assign b_inf   = (b_exp == EXP_ONES) && (b_man == '0);
    assign a_nan   = (a_exp == EXP_ONES) && (a_man != '0);
    assign b_nan   = (b_exp == EXP_ONES) && (b_man != '0);
    assign special = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    assign nan_res = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);

    logic [W-1:0] spec_c;
    logic         spec_dz, spec_inv;
    always_comb begin
        spec_c   = {sign, {(W-1){1'b0}}};
        spec_dz  = 1'b0;
        spec_inv = 1'b0;
        if (nan_res) begin
            spec_c   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            spec_inv = 1'b1;
        end else if (a_inf | b_zero) begin
            spec_c  = {sign, EXP_ONES, {MAN_W{1'b0}}};
            spec_dz = b_zero & ~a_inf;
        end
    end

    // Remainder stays below 2*mb, so a single trial subtract per bit suffices
    logic [QW:0]   diff;
    logic          q_bit;
    logic [QW-1:0] rem_sel;
    assign diff    = {1'b0, rem_q} - {3'b000, 1'b1, b_man};
    assign q_bit   = ~diff[QW];
    assign rem_sel = q_bit ? diff[QW-1:0] : rem_q;

    logic signed [EW-1:0] e_raw, e_norm, e_fin;
    logic [MAN_W-1:0]     frac, man_rnd;
    logic                 guard, sticky, inc, carry;
    logic [W-1:0]         round_c;
    always_comb begin
        e_raw = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;
        if (quo_q[QW-1]) begin
            frac   = quo_q[QW-2:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (|rem_q);
            e_norm = e_raw;
        end else begin
            frac   = quo_q[QW-3:1];
            guard  = quo_q[0];
            sticky = |rem_q;
            e_norm = e_raw - E_ONE;
        end
`ifdef FLOAT_DIVIDE_ROUND_EN
        inc = guard & (sticky | frac[0]);
`else
        inc = 1'b0;
`endif
        carry   = inc & (&frac);
        man_rnd = frac + {{(MAN_W-1){1'b0}}, inc};
        e_fin   = carry ? (e_norm + E_ONE) : e_norm;
        if (e_fin >= EMAX) begin
            round_c = {sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (e_fin[EW-1] || (e_fin == '0)) begin
            round_c = {sign, {(W-1){1'b0}}};
        end else begin
            round_c = {sign, e_fin[EXP_W-1:0], man_rnd};
        end
    end

`ifndef FLOAT_DIVIDE_ROUND_EN
    logic round_unused;
    assign round_unused = guard ^ sticky;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        dz_d    = dz_q;
        inv_d   = inv_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    rem_d   = {3'b001, a[MAN_W-1:0]};
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                if (special) begin
                    c_d     = spec_c;
                    dz_d    = spec_dz;
                    inv_d   = spec_inv;
                    state_d = DONE;
                end else begin
                    rem_d = rem_sel << 1;
                    quo_d = {quo_q[QW-2:0], q_bit};
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ROUND;
                    end
                end
            end
            ROUND: begin
                c_d     = round_c;
                dz_d    = 1'b0;
                inv_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            dz_q    <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            dz_q    <= dz_d;
            inv_q   <= inv_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign c           = c_q;
    assign div_by_zero = dz_q;
    assign invalid     = inv_q;
endmodule
`default_nettype wire

// File: tb/tb_float_divide.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_divide
// Desc     : Self-checking bench for float_divide (single and half precision).
// Revision : 1.0
// ============================================================================
module tb_float_divide;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        in_valid, in_ready, out_valid, out_ready, div_by_zero, invalid;
    logic [31:0] a, b, c;
    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_dz, h_inv;
    logic [15:0] h_a, h_b, h_c;

    float_divide #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c),
        .div_by_zero(div_by_zero), .invalid(invalid)
    );

    float_divide #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rstn(rstn), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready), .c(h_c),
        .div_by_zero(h_dz), .invalid(h_inv)
    );

    typedef struct {
        longint unsigned c;
        bit              dz;
        bit              inv;
        int              lat;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        dz;
        logic        inv;
        int          lat;
    } vec_t;

`ifdef FLOAT_DIVIDE_ROUND_EN
    localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
    localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] got_c;
    logic        got_dz, got_inv;
    int          got_lat;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Reference: exact integer quotient and remainder, then normalise/round/range
    function automatic res_t ref_div(int ew, int mw, longint unsigned av, longint unsigned bv);
        res_t            r;
        longint unsigned mmask, emaxv, ea, eb, fa, fb, sg, num, den, q, rm, sig;
        bit              az, ai, an, bz, bi, bn, g, st;
        int              e;
        mmask = (64'd1 << mw) - 1;
        emaxv = (64'd1 << ew) - 1;
        ea = (av >> mw) & emaxv;  eb = (bv >> mw) & emaxv;
        fa = av & mmask;          fb = bv & mmask;
        sg = ((av ^ bv) >> (ew + mw)) & 1;
        az = (ea == 0); ai = (ea == emaxv) && (fa == 0); an = (ea == emaxv) && (fa != 0);
        bz = (eb == 0); bi = (eb == emaxv) && (fb == 0); bn = (eb == emaxv) && (fb != 0);
        r.dz = 0; r.inv = 0; r.lat = 1;
        r.c = sg << (ew + mw);
        if (an || bn || (az && bz) || (ai && bi)) begin
            r.c = (emaxv << mw) | (64'd1 << (mw - 1));
            r.inv = 1;
        end else if (ai || bz) begin
            r.c = (sg << (ew + mw)) | (emaxv << mw);
            r.dz = bz && !ai;
        end else if (!(az || bi)) begin
            r.lat = mw + 4;
            num = ((64'd1 << mw) | fa) << (mw + 2);
            den = (64'd1 << mw) | fb;
            q = num / den;
            rm = num % den;
            e = int'(ea) - int'(eb) + (1 << (ew - 1)) - 1;
            if (((q >> (mw + 2)) & 1) != 0) begin
                sig = q >> 2; g = q[1]; st = q[0] || (rm != 0);
            end else begin
                sig = q >> 1; g = q[0]; st = (rm != 0); e = e - 1;
            end
`ifdef FLOAT_DIVIDE_ROUND_EN
            if (g && (st || sig[0])) sig = sig + 1;
            if ((sig >> (mw + 1)) != 0) begin
                sig = sig >> 1;
                e = e + 1;
            end
`endif
            if (e >= int'(emaxv)) r.c = (sg << (ew + mw)) | (emaxv << mw);
            else if (e > 0) r.c = (sg << (ew + mw)) | (64'(e) << mw) | (sig & mmask);
        end
        return r;
    endfunction

    function automatic longint unsigned gen_op(int ew, int mw);
        longint unsigned emaxv, mmask, ex, mn, sg;
        int bias, qr, k;
        emaxv = (64'd1 << ew) - 1;
        mmask = (64'd1 << mw) - 1;
        bias  = (1 << (ew - 1)) - 1;
        qr    = 1 << (ew - 2);
        k     = int'($urandom_range(0, 11));
        sg    = 64'($urandom_range(0, 1));
        mn    = {$urandom, $urandom} & mmask;
        case (k)
            0: ex = 0;
            1: begin ex = emaxv; if ($urandom_range(0, 1) == 1) mn = 0; end
            2: ex = 64'($urandom_range(1, int'(emaxv) - 1));
            3: begin ex = 64'($urandom_range(bias - qr, bias + qr)); mn = mmask; end
            default: ex = 64'($urandom_range(bias - qr, bias + qr));
        endcase
        return (sg << (ew + mw)) | (ex << mw) | mn;
    endfunction

    // hold < 0: out_ready high before out_valid; hold >= 0: backpressure for hold cycles
    task automatic sp_op(input logic [31:0] ta, input logic [31:0] tb, input int hold);
        int   n;
        res_t r;
        r = ref_div(8, 23, 64'(ta), 64'(tb));
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        chk("sp_in_ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1; a = ta; b = tb; out_ready = (hold < 0);
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        got_lat = 0;
        while (!out_valid && got_lat < 200) begin @(posedge clk); #1; got_lat++; end
        got_c = c; got_dz = div_by_zero; got_inv = invalid;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_c", 64'(c), r.c);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic hp_op(input logic [15:0] ta, input logic [15:0] tb);
        int n;
        n = 0;
        @(negedge clk);
        while (!h_in_ready && n < 100) begin @(negedge clk); n++; end
        chk("hp_in_ready_wait", 64'(h_in_ready), 64'd1);
        h_in_valid = 1'b1; h_a = ta; h_b = tb; h_out_ready = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0; h_a = 16'($urandom); h_b = 16'($urandom);
        got_lat = 0;
        while (!h_out_valid && got_lat < 200) begin @(posedge clk); #1; got_lat++; end
        got_c = {16'h0, h_c}; got_dz = h_dz; got_inv = h_inv;
        @(posedge clk); #1;
        h_out_ready = 1'b0;
        chk("hp_release_in_ready", 64'(h_in_ready), 64'd1);
    endtask

    task automatic chk_res(input string nm, input res_t r);
        chk({nm, "_c"}, 64'(got_c), r.c);
        chk({nm, "_dz"}, 64'(got_dz), 64'(r.dz));
        chk({nm, "_inv"}, 64'(got_inv), 64'(r.inv));
        chk({nm, "_lat"}, 64'(got_lat), 64'(r.lat));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[15];
        res_t        r;
        logic [31:0] ta, tb;
        logic [15:0] ha, hb;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 27};
        vecs[1]  = '{32'h3F800000, 32'h40400000, THIRD,        1'b0, 1'b0, 27};
        vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1};
        vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 1};
        vecs[4]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1};
        vecs[5]  = '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 1'b0, 1'b0, 27};
        vecs[6]  = '{32'h00800000, 32'h7F7FFFFF, 32'h00000000, 1'b0, 1'b0, 27};
        vecs[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 1};
        vecs[8]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1, 1};
        vecs[9]  = '{32'h3F800000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0, 1};
        vecs[10] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0, 1};
        vecs[11] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 1};
        vecs[12] = '{32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0, 1};
        vecs[13] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1};
        vecs[14] = '{32'h40490FDB, 32'hC0000000, 32'hBFC90FDB, 1'b0, 1'b0, 27};

        rstn = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_c", 64'(c), 64'd0);
        chk("rst_dz", 64'(div_by_zero), 64'd0);
        chk("rst_inv", 64'(invalid), 64'd0);
        chk("rst_h_in_ready", 64'(h_in_ready), 64'd1);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 15; i++) begin
            sp_op(vecs[i].a, vecs[i].b, -1);
            chk($sformatf("vec%0d_c", i), 64'(got_c), 64'(vecs[i].c));
            chk($sformatf("vec%0d_dz", i), 64'(got_dz), 64'(vecs[i].dz));
            chk($sformatf("vec%0d_inv", i), 64'(got_inv), 64'(vecs[i].inv));
            chk($sformatf("vec%0d_lat", i), 64'(got_lat), 64'(vecs[i].lat));
        end

        for (int i = 0; i < 60; i++) begin
            ta = 32'(gen_op(8, 23));
            tb = 32'(gen_op(8, 23));
            sp_op(ta, tb, -1);
            chk_res($sformatf("rnd%0d", i), ref_div(8, 23, 64'(ta), 64'(tb)));
        end

        // Backpressure, then a back-to-back operation
        sp_op(32'h40C00000, 32'h40000000, 10);
        chk_res("bp", ref_div(8, 23, 64'h40C00000, 64'h40000000));
        sp_op(32'h3F800000, 32'h40400000, 0);
        chk("b2b_c", 64'(got_c), 64'(THIRD));

        // Reset at edge 10 of a divide
        @(negedge clk);
        in_valid = 1'b1; a = 32'h40C00000; b = 32'h40000000; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_c", 64'(c), 64'd0);
        chk("midrst_dz", 64'(div_by_zero), 64'd0);
        chk("midrst_inv", 64'(invalid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        sp_op(32'h3F800000, 32'h40400000, -1);
        chk_res("postrst", ref_div(8, 23, 64'h3F800000, 64'h40400000));

        // Half precision
        hp_op(16'h3C00, 16'h4000);
        chk("hp_half_c", 64'(got_c), 64'h3800);
        chk("hp_half_lat", 64'(got_lat), 64'd14);
        hp_op(16'h3C00, 16'h0000);
        chk("hp_dz_c", 64'(got_c), 64'h7C00);
        chk("hp_dz_flag", 64'(got_dz), 64'd1);
        hp_op(16'h0000, 16'h0000);
        chk("hp_nan_c", 64'(got_c), 64'h7E00);
        chk("hp_nan_flag", 64'(got_inv), 64'd1);
        for (int i = 0; i < 30; i++) begin
            ha = 16'(gen_op(5, 10));
            hb = 16'(gen_op(5, 10));
            hp_op(ha, hb);
            chk_res($sformatf("hrnd%0d", i), ref_div(5, 10, 64'(ha), 64'(hb)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
